// File: rtl/alu_op_sequencer_if.sv
// Command, alu-drive and result signals of alu_op_sequencer, bundled for port use.
// The slave side is the sequencer; the master side is whoever feeds commands and the alu stub.
interface alu_op_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             iVALID;
  logic             oREADY;
  logic [3:0]       iA;
  logic [3:0]       iB;
  logic [3:0]       iINST;
  logic [3:0]       oALU_A;
  logic [3:0]       oALU_B;
  logic [3:0]       oALU_INST;
  logic [7:0]       iALU_RESULT;
  logic             oVALID;
  logic             iREADY;
  logic [7:0]       oRESULT;
  logic [CNT_W-1:0] oOP_CNT;
  logic             oFULL;
  logic             oEMPTY;

  modport slave (
    input  iVALID, iA, iB, iINST, iALU_RESULT, iREADY,
    output oREADY, oALU_A, oALU_B, oALU_INST, oVALID, oRESULT, oOP_CNT, oFULL, oEMPTY
  );

  modport master (
    output iVALID, iA, iB, iINST, iALU_RESULT, iREADY,
    input  oREADY, oALU_A, oALU_B, oALU_INST, oVALID, oRESULT, oOP_CNT, oFULL, oEMPTY
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Buffers (A, B, INST) commands, issues them one at a time to a combinational alu,
// registers its result and offers it downstream over a valid/ready handshake.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic              iCLK,
  input logic              iRSTn,
  alu_op_sequencer_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD
  } state_t;

  typedef struct packed {
    logic [3:0] inst;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  cmd_t             fifoMem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      fifoCount;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             push;
  logic             pop;

  state_t           state;
  state_t           nextState;
  logic             doIssue;
  logic             doCapture;
  logic             handoff;

  cmd_t             aluCmd;
  logic [7:0]       resultReg;
  logic             resultValid;
  logic [CNT_W-1:0] opCnt;

  // Full/empty come from the registered count, so a freed slot shows up one cycle after a pop.
  assign fifoFull  = (fifoCount == FULL_CNT);
  assign fifoEmpty = (fifoCount == '0);
  assign push      = bus.iVALID && !fifoFull;
  assign pop       = doIssue;
  assign handoff   = resultValid && bus.iREADY;

  // NOTE: storage has no reset; only pointers and count define which entries are live.
  always_ff @(posedge iCLK) begin
    if (push) begin
      fifoMem[wrPtr] <= '{inst: bus.iINST, a: bus.iA, b: bus.iB};
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifoCount <= fifoCount + (AW + 1)'(1);
        2'b01:   fifoCount <= fifoCount - (AW + 1)'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    nextState = state;
    doIssue   = 1'b0;
    doCapture = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          doIssue   = 1'b1;
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        doCapture = 1'b1;
        nextState = CAPTURE;
      end
      CAPTURE, HOLD: begin
        if (handoff) begin
          if (!fifoEmpty) begin
            doIssue   = 1'b1;
            nextState = ISSUE;
          end else begin
            nextState = IDLE;
          end
        end else begin
          nextState = HOLD;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // The alu inputs only move on an issue edge, so they still show the command whose result is pending.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      aluCmd      <= '0;
      resultReg   <= '0;
      resultValid <= 1'b0;
      opCnt       <= '0;
    end else begin
      if (doIssue) begin
        aluCmd <= fifoMem[rdPtr];
      end
      if (doCapture) begin
        resultReg   <= bus.iALU_RESULT;
        resultValid <= 1'b1;
      end else if (handoff) begin
        resultValid <= 1'b0;
      end
      if (handoff) begin
        opCnt <= opCnt + CNT_W'(1);
      end
    end
  end

  assign bus.oREADY    = !fifoFull;
  assign bus.oFULL     = fifoFull;
  assign bus.oEMPTY    = fifoEmpty;
  assign bus.oALU_A    = aluCmd.a;
  assign bus.oALU_B    = aluCmd.b;
  assign bus.oALU_INST = aluCmd.inst;
  assign bus.oVALID    = resultValid;
  assign bus.oRESULT   = resultReg;
  assign bus.oOP_CNT   = opCnt;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: alu stub returns {A, B}; a queue scoreboard tracks every result.
// Directed latency vectors, back-pressure/reset/wrap sequences, then randomized traffic.
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.CNT_W(CNT_W)) bus ();
  assign bus.iALU_RESULT = {bus.oALU_A, bus.oALU_B};

  alu_op_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .iCLK (clk),
    .iRSTn(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted commands queue up as their expected {A,B} result, in order.
  logic [7:0] expQ[$];
  int         expCnt      = 0;
  bit         prevValid   = 1'b0;
  bit         prevHandoff = 1'b0;
  logic [7:0] prevResult  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      expCnt      = 0;
      prevValid   = 1'b0;
      prevHandoff = 1'b0;
    end else begin
      check("op_cnt", 32'(bus.oOP_CNT), 32'(expCnt % (1 << CNT_W)));
      check("ready_vs_full", 32'(bus.oREADY), 32'(!bus.oFULL));
      if (prevValid && bus.oVALID && !prevHandoff)
        check("result_hold", 32'(bus.oRESULT), 32'(prevResult));
      if (bus.iVALID && bus.oREADY) expQ.push_back({bus.iA, bus.iB});
      prevHandoff = bus.oVALID && bus.iREADY;
      if (prevHandoff) begin
        check("result_expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          check("result_order", 32'(bus.oRESULT), 32'(expQ.pop_front()));
          expCnt++;
        end
      end
      prevValid  = bus.oVALID;
      prevResult = bus.oRESULT;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushCmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] inst);
    bit taken = 1'b0;
    bus.iVALID = 1'b1;
    bus.iA     = a;
    bus.iB     = b;
    bus.iINST  = inst;
    for (int t = 0; t < 100 && !taken; t++) begin
      taken = bus.oREADY;
      tick();
    end
    check("push_accepted", 32'(taken), 32'd1);
    bus.iVALID = 1'b0;
  endtask

  task automatic waitValid(output bit found);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      found = bus.oVALID;
    end
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      tick();
      ok = (expQ.size() == 0) && !bus.oVALID && bus.oEMPTY;
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] inst;
    logic [7:0] expRes;
  } vec_t;

  vec_t vecs[6];
  bit   flag;
  bit   acc;

  initial begin
    vecs[0] = '{a: 4'hb, b: 4'h2, inst: 4'h0, expRes: 8'hb2};
    vecs[1] = '{a: 4'h0, b: 4'h0, inst: 4'hf, expRes: 8'h00};
    vecs[2] = '{a: 4'hf, b: 4'hf, inst: 4'h7, expRes: 8'hff};
    vecs[3] = '{a: 4'h5, b: 4'ha, inst: 4'h3, expRes: 8'h5a};
    vecs[4] = '{a: 4'ha, b: 4'h5, inst: 4'hc, expRes: 8'ha5};
    vecs[5] = '{a: 4'h1, b: 4'he, inst: 4'h9, expRes: 8'h1e};

    bus.iVALID = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iINST  = '0;
    bus.iREADY = 1'b0;

    // Reset levels
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.oVALID), 32'd0);
    check("rst_result", 32'(bus.oRESULT), 32'h00);
    check("rst_cnt", 32'(bus.oOP_CNT), 32'd0);
    check("rst_empty", 32'(bus.oEMPTY), 32'd1);
    check("rst_full", 32'(bus.oFULL), 32'd0);
    check("rst_ready", 32'(bus.oREADY), 32'd1);
    check("rst_alu_a", 32'(bus.oALU_A), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single-op latency vectors: accept at N, issue at N+1, valid after N+2, handoff at N+3.
    bus.iREADY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.iVALID = 1'b1;
      bus.iA     = vecs[i].a;
      bus.iB     = vecs[i].b;
      bus.iINST  = vecs[i].inst;
      check("vec_ready", 32'(bus.oREADY), 32'd1);
      tick();
      bus.iVALID = 1'b0;
      check("vec_valid_n", 32'(bus.oVALID), 32'd0);
      tick();
      check("vec_alu_a", 32'(bus.oALU_A), 32'(vecs[i].a));
      check("vec_alu_b", 32'(bus.oALU_B), 32'(vecs[i].b));
      check("vec_alu_inst", 32'(bus.oALU_INST), 32'(vecs[i].inst));
      check("vec_valid_n1", 32'(bus.oVALID), 32'd0);
      tick();
      check("vec_valid_n2", 32'(bus.oVALID), 32'd1);
      check("vec_result", 32'(bus.oRESULT), 32'(vecs[i].expRes));
      tick();
      check("vec_valid_n3", 32'(bus.oVALID), 32'd0);
      check("vec_cnt", 32'(bus.oOP_CNT), 32'((i + 1) % (1 << CNT_W)));
      check("vec_empty", 32'(bus.oEMPTY), 32'd1);
    end

    // Instruction sweep: back-to-back results two cycles apart, in order.
    fork
      begin
        for (int k = 0; k < 16; k++) pushCmd(4'hb, 4'h2, 4'(k));
      end
      begin
        int lastCyc = 0;
        bit found;
        for (int k = 0; k < 16; k++) begin
          found = 1'b0;
          for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            found = bus.oVALID;
          end
          check("sweep_valid", 32'(found), 32'd1);
          check("sweep_result", 32'(bus.oRESULT), 32'hb2);
          check("sweep_inst", 32'(bus.oALU_INST), 32'(k));
          if (k > 0) check("sweep_spacing", 32'(cyc - lastCyc), 32'd2);
          lastCyc = cyc;
          @(posedge clk);
        end
      end
    join
    #1;
    check("sweep_cnt", 32'(bus.oOP_CNT), 32'((6 + 16) % (1 << CNT_W)));
    waitIdle(flag);
    check("sweep_idle", 32'(flag), 32'd1);

    // Back-pressure: one result held, four queued, fifth held off until a slot frees.
    bus.iREADY = 1'b0;
    pushCmd(4'h1, 4'h1, 4'h0);
    waitValid(flag);
    check("bp_first_valid", 32'(flag), 32'd1);
    for (int i = 0; i < 4; i++) pushCmd(4'(4'h2 + i), 4'h3, 4'(i));
    check("bp_full", 32'(bus.oFULL), 32'd1);
    check("bp_ready_low", 32'(bus.oREADY), 32'd0);
    bus.iVALID = 1'b1;
    bus.iA     = 4'h9;
    bus.iB     = 4'h9;
    bus.iINST  = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_ready", 32'(bus.oREADY), 32'd0);
      check("bp_hold_result", 32'(bus.oRESULT), 32'h11);
      check("bp_hold_valid", 32'(bus.oVALID), 32'd1);
    end
    bus.iREADY = 1'b1;
    tick();
    check("bp_slot_freed", 32'(bus.oREADY), 32'd1);
    check("bp_not_full", 32'(bus.oFULL), 32'd0);
    tick();
    bus.iVALID = 1'b0;
    check("bp_fifth_taken", 32'(bus.oFULL), 32'd1);
    waitIdle(flag);
    check("bp_drained", 32'(flag), 32'd1);

    // Reset while holding a result with three commands queued.
    bus.iREADY = 1'b0;
    pushCmd(4'h3, 4'h4, 4'h1);
    waitValid(flag);
    check("mid_first_valid", 32'(flag), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) pushCmd(4'(4'h6 + i), 4'h7, 4'h2);
    rst_n = 1'b0;
    #1;
    check("mid_valid_drop", 32'(bus.oVALID), 32'd0);
    check("mid_empty", 32'(bus.oEMPTY), 32'd1);
    check("mid_cnt", 32'(bus.oOP_CNT), 32'd0);
    repeat (2) tick();
    rst_n      = 1'b1;
    bus.iREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mid_no_stale", 32'(bus.oVALID), 32'd0);
    end
    check("mid_cnt_after", 32'(bus.oOP_CNT), 32'd0);

    // Counter wrap: 17 completions on a 4-bit counter.
    for (int i = 0; i < 17; i++) pushCmd(4'(i), 4'(15 - i), 4'(i));
    waitIdle(flag);
    check("wrap_idle", 32'(flag), 32'd1);
    check("wrap_cnt", 32'(bus.oOP_CNT), 32'(17 % (1 << CNT_W)));

    // Randomized traffic; upstream holds an unaccepted command stable.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = bus.iVALID && bus.oREADY;
      @(posedge clk);
      #1;
      if (!bus.iVALID || acc) begin
        bus.iVALID = 1'($urandom_range(0, 1));
        bus.iA     = 4'($urandom);
        bus.iB     = 4'($urandom);
        bus.iINST  = 4'($urandom);
      end
      bus.iREADY = ($urandom_range(0, 9) < 6);
    end
    bus.iVALID = 1'b0;
    bus.iREADY = 1'b1;
    waitIdle(flag);
    check("rand_drained", 32'(flag), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
